mc8051_mem_responder: RTL

Memory-side responder for the core's naive memory interface: the slave that answers the bus interface unit's `mem_psen_n` / `mem_rd_n` / `mem_we_n` strobes. It decodes each access and routes it to a synchronous code-ROM port (program fetch) or a synchronous XRAM port (MOVX read/write). It inserts a programmable number of wait states and returns `mem_rdata` with a level `mem_data_rdy` handshake. It sits between the core's BIU and the on-chip block memories.

---
 rtl/mc8051_mem_responder_pkg.sv | 35 +++
 rtl/mc8051_mem_responder_if.sv | 24 ++
 rtl/mc8051_mem_wait_cnt.sv | 27 ++
 rtl/mc8051_mem_responder.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mc8051_mem_responder_pkg.sv
// mc8051_mem_responder_pkg: FSM state encodings, access-type codes and strobe decode helpers.
`default_nettype none

package mc8051_mem_responder_pkg;

  typedef enum logic [2:0] {
    MR_IDLE  = 3'd0,
    MR_ISSUE = 3'd1,
    MR_LAT   = 3'd2,
    MR_WAIT  = 3'd3,
    MR_HOLD  = 3'd4
  } mr_state_t;

  typedef enum logic [1:0] {
    ACC_NONE = 2'd0,
    ACC_CODE = 2'd1,
    ACC_XRD  = 2'd2,
    ACC_XWR  = 2'd3
  } acc_t;

  // Priority psen > rd > we
  function automatic acc_t decode_acc(input logic psen_n, input logic rd_n, input logic we_n);
    if (!psen_n)    return ACC_CODE;
    else if (!rd_n) return ACC_XRD;
    else if (!we_n) return ACC_XWR;
    else            return ACC_NONE;
  endfunction

  function automatic logic multi_strobe(input logic psen_n, input logic rd_n, input logic we_n);
    return (!psen_n && !rd_n) || (!psen_n && !we_n) || (!rd_n && !we_n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc8051_mem_responder_if.sv
// mc8051_mem_responder_if: naive memory bus between the core's BIU (master) and the responder (slave).
`default_nettype none

interface mc8051_mem_responder_if;
  logic        mem_we_n;
  logic        mem_rd_n;
  logic        mem_psen_n;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_data_rdy;
  logic [7:0]  mem_rdata;

  modport master (
    output mem_we_n, mem_rd_n, mem_psen_n, mem_addr, mem_wdata,
    input  mem_data_rdy, mem_rdata
  );

  modport slave (
    input  mem_we_n, mem_rd_n, mem_psen_n, mem_addr, mem_wdata,
    output mem_data_rdy, mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/mc8051_mem_wait_cnt.sv
// mc8051_mem_wait_cnt: 4-bit loadable down-counter; o_done flags the last wait cycle (count == 1).
`default_nettype none

module mc8051_mem_wait_cnt (
  input  wire logic       clk,
  input  wire logic       reset_n,
  input  wire logic       i_load,
  input  wire logic [3:0] i_load_val,
  output logic            o_done
);

  logic [3:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_cnt <= 4'd0;
    else if (i_load)
      r_cnt <= i_load_val;
    else if (r_cnt != 4'd0)
      r_cnt <= r_cnt - 4'd1;
  end

  assign o_done = (r_cnt == 4'd1);

endmodule

`default_nettype wire

// File: rtl/mc8051_mem_responder.sv
// mc8051_mem_responder: answers BIU psen/rd/we strobes, routes them to code-ROM or XRAM ports
// with programmable wait states, and returns registered read data with a level ready.
`default_nettype none

module mc8051_mem_responder
  import mc8051_mem_responder_pkg::*;
#(
  parameter int CODE_AW   = 16,
  parameter int XRAM_AW   = 11,
  parameter int CODE_WAIT = 0,
  parameter int XRAM_WAIT = 1
) (
  input  wire logic                clk,
  input  wire logic                reset_n,
  mc8051_mem_responder_if.slave    mem,
  output logic                     code_en,
  output logic [CODE_AW-1:0]       code_addr,
  input  wire logic [7:0]          code_rdata,
  output logic                     xram_en,
  output logic                     xram_we,
  output logic [XRAM_AW-1:0]       xram_addr,
  output logic [7:0]               xram_wdata,
  input  wire logic [7:0]          xram_rdata,
  output logic                     o_proto_err
);

  localparam logic [3:0] CODE_WAIT_4 = 4'(CODE_WAIT);
  localparam logic [3:0] XRAM_WAIT_4 = 4'(XRAM_WAIT);

  mr_state_t   r_state, w_nxt_state;
  acc_t        r_type, w_acc;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata, r_rdata;
  logic        r_rdy, r_code_en, r_xram_en, r_xram_we, r_proto_err;

  logic        w_any, w_latch, w_capture, w_cnt_load, w_cnt_done;
  logic        w_nxt_rdy, w_nxt_code_en, w_nxt_xram_en, w_nxt_xram_we;
  logic [3:0]  w_wait;

  assign w_acc  = decode_acc(mem.mem_psen_n, mem.mem_rd_n, mem.mem_we_n);
  assign w_any  = (w_acc != ACC_NONE);
  assign w_wait = (r_type == ACC_CODE) ? CODE_WAIT_4 : XRAM_WAIT_4;

  mc8051_mem_wait_cnt u_wait_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_cnt_load),
    .i_load_val (w_wait),
    .o_done     (w_cnt_done)
  );

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_rdy     = r_rdy;
    w_nxt_code_en = 1'b0;
    w_nxt_xram_en = 1'b0;
    w_nxt_xram_we = 1'b0;
    w_latch       = 1'b0;
    w_capture     = 1'b0;
    w_cnt_load    = 1'b0;
    case (r_state)
      MR_IDLE: begin
        if (w_any) begin
          w_latch     = 1'b1;
          w_nxt_state = MR_ISSUE;
        end
      end
      MR_ISSUE: begin
        w_nxt_state = w_any ? MR_LAT : MR_IDLE;
      end
      MR_LAT: begin
        if (!w_any) begin
          w_nxt_state = MR_IDLE;
        end else if (w_wait != 4'd0) begin
          w_cnt_load  = 1'b1;
          w_nxt_state = MR_WAIT;
        end else begin
          w_capture   = 1'b1;
          w_nxt_rdy   = 1'b1;
          w_nxt_state = MR_HOLD;
        end
      end
      MR_WAIT: begin
        if (!w_any) begin
          w_nxt_state = MR_IDLE;
        end else if (w_cnt_done) begin
          w_capture   = 1'b1;
          w_nxt_rdy   = 1'b1;
          w_nxt_state = MR_HOLD;
        end
      end
      MR_HOLD: begin
        if (!w_any) begin
          w_nxt_rdy   = 1'b0;
          w_nxt_state = MR_IDLE;
        end else if ((mem.mem_addr != r_addr) || (w_acc != r_type)) begin
          // BIU moved to its next phase without releasing the strobes
          w_latch     = 1'b1;
          w_nxt_rdy   = 1'b0;
          w_nxt_state = MR_ISSUE;
        end
      end
      default: begin
        w_nxt_rdy   = 1'b0;
        w_nxt_state = MR_IDLE;
      end
    endcase
    if (w_latch) begin
      w_nxt_code_en = (w_acc == ACC_CODE);
      w_nxt_xram_en = (w_acc == ACC_XRD) || (w_acc == ACC_XWR);
      w_nxt_xram_we = (w_acc == ACC_XWR);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= MR_IDLE;
      r_type      <= ACC_NONE;
      r_addr      <= 16'h0000;
      r_wdata     <= 8'hFF;
      r_rdata     <= 8'hFF;
      r_rdy       <= 1'b0;
      r_code_en   <= 1'b0;
      r_xram_en   <= 1'b0;
      r_xram_we   <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_rdy     <= w_nxt_rdy;
      r_code_en <= w_nxt_code_en;
      r_xram_en <= w_nxt_xram_en;
      r_xram_we <= w_nxt_xram_we;
      if (w_latch) begin
        r_addr  <= mem.mem_addr;
        r_type  <= w_acc;
        r_wdata <= mem.mem_wdata;
      end
      if (w_capture && (r_type != ACC_XWR))
        r_rdata <= (r_type == ACC_CODE) ? code_rdata : xram_rdata;
      if (multi_strobe(mem.mem_psen_n, mem.mem_rd_n, mem.mem_we_n))
        r_proto_err <= 1'b1;
    end
  end

  assign mem.mem_data_rdy = r_rdy;
  assign mem.mem_rdata    = r_rdata;
  assign code_en          = r_code_en;
  assign code_addr        = r_addr[CODE_AW-1:0];
  assign xram_en          = r_xram_en;
  assign xram_we          = r_xram_we;
  assign xram_addr        = r_addr[XRAM_AW-1:0];
  assign xram_wdata       = r_wdata;
  assign o_proto_err      = r_proto_err;

endmodule

`default_nettype wire
